// File: rtl/serial_addsub_ctrl.sv
// Bit-serial adder/subtractor sequencer driving an external 1-bit full-adder cell, LSB first.
// done pulses WIDTH+1 edges after the accepted start; start is ignored while busy.
module serial_addsub_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_cin,
  input  logic             fa_s,
  input  logic             fa_c,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_shift;
  logic [WIDTH-1:0] b_shift;
  logic             sub_q;
  logic             carry;
  logic [CW-1:0]    cnt;

  // Subtraction is a + ~b + 1: invert b per bit and seed the carry with 1.
  assign fa_a   = (state == RUN) & a_shift[0];
  assign fa_b   = (state == RUN) & (b_shift[0] ^ sub_q);
  assign fa_cin = (state == RUN) & carry;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      a_shift <= '0;
      b_shift <= '0;
      sub_q   <= 1'b0;
      carry   <= 1'b0;
      cnt     <= '0;
      result  <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_shift <= a;
            b_shift <= b;
            sub_q   <= sub;
            carry   <= sub;
            cnt     <= '0;
            result  <= '0;
            cout    <= 1'b0;
            ovf     <= 1'b0;
            busy    <= 1'b1;
            state   <= RUN;
          end
        end
        RUN: begin
          carry   <= fa_c;
          result  <= (result >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));
          a_shift <= a_shift >> 1;
          b_shift <= b_shift >> 1;
          cnt     <= cnt + 1'b1;
          // carry still holds the carry into the MSB here, fa_c is the carry out of it.
          if (cnt == LAST) begin
            ovf   <= carry ^ fa_c;
            cout  <= fa_c;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// Directed and swept checks of serial_addsub_ctrl with ideal full-adder cells (WIDTH=8 and WIDTH=1).
module tb_serial_addsub_ctrl;

  logic       clk = 1'b0;
  logic       rst, start, sub;
  logic [7:0] a, b;
  logic       fa_a, fa_b, fa_cin, fa_s, fa_c;
  logic       busy, done, cout, ovf;
  logic [7:0] result;

  logic start1, sub1, a1, b1;
  logic fa_a1, fa_b1, fa_cin1, fa_s1, fa_c1;
  logic busy1, done1, result1, cout1, ovf1;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  assign fa_s  = fa_a ^ fa_b ^ fa_cin;
  assign fa_c  = (fa_a & fa_b) | (fa_a & fa_cin) | (fa_b & fa_cin);
  assign fa_s1 = fa_a1 ^ fa_b1 ^ fa_cin1;
  assign fa_c1 = (fa_a1 & fa_b1) | (fa_a1 & fa_cin1) | (fa_b1 & fa_cin1);

  serial_addsub_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b),
    .fa_a(fa_a), .fa_b(fa_b), .fa_cin(fa_cin), .fa_s(fa_s), .fa_c(fa_c),
    .busy(busy), .done(done), .result(result), .cout(cout), .ovf(ovf)
  );

  serial_addsub_ctrl #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .sub(sub1), .a(a1), .b(b1),
    .fa_a(fa_a1), .fa_b(fa_b1), .fa_cin(fa_cin1), .fa_s(fa_s1), .fa_c(fa_c1),
    .busy(busy1), .done(done1), .result(result1), .cout(cout1), .ovf(ovf1)
  );

  // Drives one start cycle; returns #1 after the start edge.
  task automatic start_op(input logic [7:0] ai, input logic [7:0] bi, input logic s);
    a = ai; b = bi; sub = s; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Counts edges from the start edge (inclusive) until done is seen; optional start re-pulse.
  task automatic wait_done(input bit repulse, output int lat);
    lat = 1;
    while (!done && lat < 40) begin
      start = (repulse && lat == 4);
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
    start1 = 1'b0; sub1 = 1'b0; a1 = 1'b0; b1 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    tests++;
    if ({busy, done, result, cout, ovf} !== 12'h000) begin
      fails++;
      $display("FAIL reset_outputs: got busy=%b done=%b result=%h cout=%b ovf=%b, want all 0",
               busy, done, result, cout, ovf);
    end
    tests++;
    if ({fa_a, fa_b, fa_cin} !== 3'b000) begin
      fails++;
      $display("FAIL reset_fa: got %b, want 000", {fa_a, fa_b, fa_cin});
    end
  endtask

  task automatic test_add;
    logic [7:0] av [2] = '{8'h35, 8'h7F};
    logic [7:0] bv [2] = '{8'h4A, 8'h01};
    logic [9:0] ev [2] = '{{8'h7F, 1'b0, 1'b0}, {8'h80, 1'b0, 1'b1}};
    int lat;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      start_op(av[i], bv[i], 1'b0);
      tests++;
      if (busy !== 1'b1 || fa_cin !== 1'b0) begin
        fails++;
        $display("FAIL add_run_%0d: busy=%b fa_cin=%b, want 1 0", i, busy, fa_cin);
      end
      wait_done(1'b0, lat);
      tests++;
      if (lat !== 9) begin
        fails++;
        $display("FAIL add_latency_%0d: got %0d, want 9", i, lat);
      end
      tests++;
      if ({result, cout, ovf} !== ev[i]) begin
        fails++;
        $display("FAIL add_result_%0d: got %h/%b/%b, want %h/%b/%b", i, result, cout, ovf,
                 ev[i][9:2], ev[i][1], ev[i][0]);
      end
      @(posedge clk); #1;
      tests++;
      if (done !== 1'b0 || busy !== 1'b0 || {result, cout, ovf} !== ev[i]) begin
        fails++;
        $display("FAIL add_hold_%0d: done=%b busy=%b result=%h, want 0 0 %h", i, done, busy,
                 result, ev[i][9:2]);
      end
    end
  endtask

  task automatic test_sub;
    logic [7:0] av [2] = '{8'h10, 8'h80};
    logic [7:0] bv [2] = '{8'h20, 8'h01};
    logic [9:0] ev [2] = '{{8'hF0, 1'b0, 1'b0}, {8'h7F, 1'b1, 1'b1}};
    int lat;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      start_op(av[i], bv[i], 1'b1);
      tests++;
      if (fa_cin !== 1'b1) begin
        fails++;
        $display("FAIL sub_cin_%0d: got %b, want 1", i, fa_cin);
      end
      wait_done(1'b0, lat);
      tests++;
      if (lat !== 9 || {result, cout, ovf} !== ev[i]) begin
        fails++;
        $display("FAIL sub_result_%0d: lat=%0d %h/%b/%b, want 9 %h/%b/%b", i, lat, result, cout,
                 ovf, ev[i][9:2], ev[i][1], ev[i][0]);
      end
      tests++;
      if ({fa_a, fa_b, fa_cin} !== 3'b000) begin
        fails++;
        $display("FAIL sub_fa_done_%0d: got %b, want 000", i, {fa_a, fa_b, fa_cin});
      end
    end
  endtask

  task automatic test_restart_ignored;
    int lat, ndone;
    @(posedge clk); #1;
    start_op(8'hFF, 8'hFF, 1'b0);
    wait_done(1'b1, lat);
    ndone = done ? 1 : 0;
    a = 8'h00; b = 8'h00;
    repeat (3) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    tests++;
    if (lat !== 9 || {result, cout, ovf} !== {8'hFE, 1'b1, 1'b0}) begin
      fails++;
      $display("FAIL restart_result: lat=%0d %h/%b/%b, want 9 fe/1/0", lat, result, cout, ovf);
    end
    tests++;
    if (ndone !== 1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL restart_single_done: dones=%0d busy=%b, want 1 0", ndone, busy);
    end
  endtask

  task automatic test_reset_mid_run;
    int ndone = 0;
    int lat;
    @(posedge clk); #1;
    start_op(8'h12, 8'h34, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    tests++;
    if ({busy, done, result, cout, ovf, fa_a, fa_b, fa_cin} !== 15'h0) begin
      fails++;
      $display("FAIL midrst_clear: busy=%b done=%b result=%h cout=%b ovf=%b fa=%b, want all 0",
               busy, done, result, cout, ovf, {fa_a, fa_b, fa_cin});
    end
    repeat (12) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    tests++;
    if (ndone !== 0) begin
      fails++;
      $display("FAIL midrst_no_done: got %0d pulses, want 0", ndone);
    end
    start_op(8'h12, 8'h34, 1'b0);
    wait_done(1'b0, lat);
    tests++;
    if (lat !== 9 || result !== 8'h46 || cout !== 1'b0 || ovf !== 1'b0) begin
      fails++;
      $display("FAIL midrst_recover: lat=%0d result=%h cout=%b ovf=%b, want 9 46 0 0", lat,
               result, cout, ovf);
    end
  endtask

  task automatic test_back_to_back;
    int lat;
    @(posedge clk); #1;
    start_op(8'hC0, 8'h50, 1'b0);
    wait_done(1'b0, lat);
    @(posedge clk); #1;
    tests++;
    if (busy !== 1'b0 || result !== 8'h10 || cout !== 1'b1) begin
      fails++;
      $display("FAIL b2b_first: busy=%b result=%h cout=%b, want 0 10 1", busy, result, cout);
    end
    start_op(8'h05, 8'h03, 1'b1);
    tests++;
    if (busy !== 1'b1 || result !== 8'h00 || cout !== 1'b0) begin
      fails++;
      $display("FAIL b2b_clear: busy=%b result=%h cout=%b, want 1 00 0", busy, result, cout);
    end
    wait_done(1'b0, lat);
    tests++;
    if (lat !== 9 || result !== 8'h02 || cout !== 1'b1 || ovf !== 1'b0) begin
      fails++;
      $display("FAIL b2b_second: lat=%0d result=%h cout=%b ovf=%b, want 9 02 1 0", lat, result,
               cout, ovf);
    end
  endtask

  task automatic test_width1;
    int lat;
    logic [1:0] ext;
    logic eo;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      a1 = i[0]; b1 = i[1]; sub1 = i[2]; start1 = 1'b1;
      ext = sub1 ? ({1'b0, a1} + {1'b0, ~b1} + 2'd1) : ({1'b0, a1} + {1'b0, b1});
      eo  = sub1 ? (a1 != b1 && ext[0] != a1) : (a1 == b1 && ext[0] != a1);
      @(posedge clk); #1;
      start1 = 1'b0;
      lat = 1;
      while (!done1 && lat < 10) begin
        @(posedge clk); #1;
        lat++;
      end
      tests++;
      if (lat !== 2 || {result1, cout1, ovf1} !== {ext[0], ext[1], eo}) begin
        fails++;
        $display("FAIL width1_%0d: lat=%0d r/c/o=%b%b%b, want 2 %b%b%b", i, lat, result1, cout1,
                 ovf1, ext[0], ext[1], eo);
      end
    end
  endtask

  task automatic test_random_sweep;
    int lat;
    logic [7:0] ra, rb;
    logic rs, eo;
    logic [8:0] ext;
    for (int n = 0; n < 1000; n++) begin
      ra = 8'($urandom_range(255));
      rb = 8'($urandom_range(255));
      rs = 1'($urandom_range(1));
      ext = rs ? ({1'b0, ra} + {1'b0, ~rb} + 9'd1) : ({1'b0, ra} + {1'b0, rb});
      eo  = rs ? (ra[7] != rb[7] && ext[7] != ra[7]) : (ra[7] == rb[7] && ext[7] != ra[7]);
      @(posedge clk); #1;
      start_op(ra, rb, rs);
      wait_done(1'b0, lat);
      tests++;
      if (lat !== 9 || {cout, result, ovf} !== {ext, eo}) begin
        fails++;
        $display("FAIL sweep_%0d: %h %s %h -> lat=%0d %b/%h/%b, want 9 %b/%h/%b", n, ra,
                 rs ? "-" : "+", rb, lat, cout, result, ovf, ext[8], ext[7:0], eo);
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_restart_ignored();
    test_reset_mid_run();
    test_back_to_back();
    test_width1();
    test_random_sweep();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/serial_addsub_ctrl.md
SERIAL_ADDSUB_CTRL -- requirements
Module: serial_addsub_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the operand width in bits (legal range 1..32).
REQ-002 SHALL have port clk  input  1  clock; all state changes on the rising edge.
REQ-003 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-004 SHALL have port start  input  1  request to begin an operation; sampled only in IDLE.
REQ-005 SHALL have port sub  input  1  operation select, 0 = a+b, 1 = a-b; sampled with start.
REQ-006 SHALL have port a  input  WIDTH  first operand; sampled with start.
REQ-007 SHALL have port b  input  WIDTH  second operand; sampled with start.
REQ-008 SHALL have port fa_a  output  1  bit to the external 1-bit full-adder cell, input a.
REQ-009 SHALL have port fa_b  output  1  bit to the full-adder cell, input b.
REQ-010 SHALL have port fa_cin  output  1  carry to the full-adder cell, input cin.
REQ-011 SHALL have port fa_s  input  1  sum returned by the full-adder cell; combinational from fa_a/fa_b/fa_cin.
REQ-012 SHALL have port fa_c  input  1  carry returned by the full-adder cell; combinational from fa_a/fa_b/fa_cin.
REQ-013 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-014 SHALL have port done  output  1  one-cycle pulse; result valid.
REQ-015 SHALL have port result  output  WIDTH  sum or difference, modulo 2^WIDTH.
REQ-016 SHALL have port cout  output  1  final carry out; for subtract, 1 = no borrow.
REQ-017 SHALL have port ovf  output  1  two's-complement signed overflow.

Function
REQ-018 SHALL implement FSM states IDLE, RUN, DONE.
REQ-019 SHALL, in IDLE with start=1 at an edge: latch a and b into shift registers; latch sub; load carry register with sub; clear bit counter; enter RUN.
REQ-020 SHALL, in RUN, drive the following: fa_a = a_shift[0]; fa_b = b_shift[0] XOR sub_q; fa_cin = carry register.
REQ-021 SHALL, at each RUN edge: load carry register from fa_c; shift fa_s into the result register MSB with a right shift; shift a_shift and b_shift right; increment the counter.
REQ-022 SHALL, at the RUN edge that processes bit WIDTH-1: capture ovf = (carry register XOR fa_c); capture cout = fa_c; enter DONE.
REQ-023 SHALL assert done for exactly the one DONE cycle, then return to IDLE.
REQ-024 SHALL give a fixed latency: done is high in the cycle after the edge that sampled start plus WIDTH edges, i.e. WIDTH+1 edges after the start edge.
REQ-025 SHALL drive fa_a, fa_b and fa_cin to 0 in IDLE and in DONE.
REQ-026 SHALL ignore start while in RUN or DONE; no queuing, and operands are not resampled.
REQ-027 SHALL hold result, cout and ovf stable from DONE until the next accepted start, then clear them to 0 on that start edge.
REQ-028 SHALL size the bit counter at clog2(WIDTH)+1 bits.
REQ-029 SHALL, for WIDTH=1, process a single RUN cycle and pass from RUN to DONE with no wrap.
REQ-030 SHALL allow back-to-back operation: start high in the IDLE cycle directly after DONE is accepted, giving one idle cycle between operations.

Reset
REQ-031 SHALL, with rst=1 at an edge, force state IDLE and clear busy, done, result, cout, ovf, the counter, the carry register and the shift registers to 0.
REQ-032 SHALL give rst priority over start and over every FSM transition.
REQ-033 SHALL, on rst during RUN, abort the operation with no done pulse; the partial result is discarded.

Verification
REQ-034 SHALL be covered by this scenario: WIDTH=8, a=8'h35, b=8'h4A, sub=0 -> done 9 edges after start; result=8'h7F, cout=0, ovf=0.
REQ-035 SHALL be covered by this scenario: a=8'h7F, b=8'h01, sub=0 -> result=8'h80, cout=0, ovf=1.
REQ-036 SHALL be covered by this scenario: a=8'h10, b=8'h20, sub=1 -> result=8'hF0, cout=0 (borrow), ovf=0; a=8'h80, b=8'h01, sub=1 -> result=8'h7F, cout=1, ovf=1.
REQ-037 SHALL be covered by this scenario: a=8'hFF, b=8'hFF, sub=0, with start re-pulsed mid-RUN -> the re-pulse is ignored; result=8'hFE, cout=1, ovf=0; exactly one done pulse.
REQ-038 SHALL be covered by this scenario: rst asserted at the 4th RUN edge -> next cycle busy=0, done never pulses, all outputs 0; a following start completes normally.
REQ-039 SHALL be covered by this scenario: a randomized sweep of 1000 operand/sub triples with the cell modelled as an ideal full adder -> result, cout and ovf match the reference arithmetic, and the done spacing equals WIDTH+1 edges.
